// File: rtl/nanov_pkg.sv
// Shared constants and types for the nanoV SPI instruction fetch path.
package nanov_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [7:0]  SPI_READ  = 8'h03;

    typedef enum logic [1:0] {FLUSH, CMD, FILL, RUN} fetch_state_t;

    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/nanov_cycle_decode.sv
// Number of 32-clock sub-cycles the core needs for the current instruction.
module nanov_cycle_decode
    import nanov_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic       mul_bit,
    input  logic [2:0] funct3,
    output logic [1:0] ncyc
);

    always_comb begin
        ncyc = 2'd1;
        if (opcode == OP_JAL || opcode == OP_JALR || opcode == OP_BRANCH) begin
            ncyc = 2'd2;
        end else if (opcode == OP_LOAD) begin
            ncyc = 2'd3;
        end else if (opcode == OP_OP && mul_bit) begin
            ncyc = 2'd3;
        end else if ((opcode == OP_OPIMM || opcode == OP_OP) &&
                     (funct3 == F3_SLL || funct3 == F3_SRX)) begin
            ncyc = 2'd2;
        end
    end

endmodule

// File: rtl/nanov_spi_fetch.sv
// SPI flash instruction fetch sequencer and timebase for the nanoV core.
// Optional NANOV_FETCH_REDIRECT_CNT_EN adds a saturating taken-branch counter.
module nanov_spi_fetch
    import nanov_pkg::*;
#(
    parameter logic [23:0] RESET_ADDR = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_miso,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_clk_en,
    input  logic        branch,
    input  logic [23:0] branch_target,
    output logic [29:0] instr,
    output logic [28:0] next_instr,
    output logic [2:0]  cycle,
    output logic [4:0]  counter,
    output logic        pc
`ifdef NANOV_FETCH_REDIRECT_CNT_EN
    ,
    output logic [15:0] redirect_cnt
`endif
);

    fetch_state_t state, state_nxt;
    logic [2:0]  cycle_nxt;
    logic [4:0]  cnt_nxt;
    logic [23:0] pc_reg, pc_nxt;
    logic [31:2] instr_q;
    logic [31:2] asm_q;
    logic [31:2] word_done;
    logic [31:0] cmd_word;
    logic [4:0]  bit_idx;
    logic [1:0]  ncyc;
    logic [2:0]  last_cycle;
    logic        slot_end, sample, retire, take_branch, branch_pending;

    nanov_cycle_decode u_decode (
        .opcode (instr_q[6:2]),
        .mul_bit(instr_q[25]),
        .funct3 (instr_q[14:12]),
        .ncyc   (ncyc)
    );

    assign slot_end    = (counter == 5'd31);
    assign cnt_nxt     = counter + 5'd1;
    assign sample      = (state == FILL) || (state == RUN && cycle == 3'd0);
    assign last_cycle  = {1'b0, ncyc} - 3'd1;
    assign retire      = (state == RUN) && slot_end && (cycle >= last_cycle);
    assign take_branch = retire && (branch_pending || branch);
    // Byte order on the wire is address order, bits MSB-first within a byte.
    assign bit_idx     = {counter[4:3], ~counter[2:0]};

    assign instr      = instr_q;
    assign next_instr = asm_q[30:2];
    assign pc         = (counter[4:3] == 2'b11) ? 1'b0 : pc_reg[counter];

    // Bit 24 arrives on the same edge that hands the word over.
    always_comb begin
        word_done = asm_q;
        if (sample) begin
            word_done[24] = spi_miso;
        end
    end

    always_comb begin
        state_nxt = state;
        cycle_nxt = cycle;
        pc_nxt    = pc_reg;
        if (slot_end) begin
            case (state)
                FLUSH: state_nxt = CMD;
                CMD:   state_nxt = FILL;
                FILL:  state_nxt = RUN;
                RUN: begin
                    if (retire) begin
                        cycle_nxt = 3'd0;
                        if (take_branch) begin
                            state_nxt = FLUSH;
                            pc_nxt    = {branch_target[23:2], 2'b00};
                        end else begin
                            pc_nxt = pc_reg + 24'd4;
                        end
                    end else begin
                        cycle_nxt = cycle + 3'd1;
                    end
                end
                default: state_nxt = FLUSH;
            endcase
        end
        cmd_word = {SPI_READ, pc_nxt};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= FLUSH;
            counter        <= 5'd0;
            cycle          <= 3'd0;
            pc_reg         <= {RESET_ADDR[23:2], 2'b00};
            instr_q        <= NOP_INSTR[31:2];
            branch_pending <= 1'b0;
            spi_cs_n       <= 1'b1;
            spi_mosi       <= 1'b0;
            spi_clk_en     <= 1'b0;
        end else begin
            counter <= cnt_nxt;
            state   <= state_nxt;
            cycle   <= cycle_nxt;
            pc_reg  <= pc_nxt;
            if (slot_end && state == FILL) begin
                instr_q <= word_done;
            end else if (retire) begin
                instr_q <= take_branch ? NOP_INSTR[31:2] : word_done;
            end
            if (retire) begin
                branch_pending <= 1'b0;
            end else if (state == RUN && branch) begin
                branch_pending <= 1'b1;
            end
            // Outputs are registered from next-state values so they are valid for the whole clock.
            spi_cs_n   <= (state_nxt == FLUSH);
            spi_clk_en <= (state_nxt == CMD) || (state_nxt == FILL) ||
                          (state_nxt == RUN && cycle_nxt == 3'd0);
            spi_mosi   <= (state_nxt == CMD) ? cmd_word[~cnt_nxt] : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (sample) begin
            for (int i = 2; i < 32; i++) begin
                if (i[4:0] == bit_idx) begin
                    asm_q[i] <= spi_miso;
                end
            end
        end
    end

`ifdef NANOV_FETCH_REDIRECT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt <= 16'd0;
        end else if (take_branch && redirect_cnt != 16'hFFFF) begin
            redirect_cnt <= redirect_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nanov_spi_fetch.sv
// Directed bench for nanov_spi_fetch with a behavioural SPI READ flash.
module tb_nanov_spi_fetch;

    logic        clk;
    logic        rst;
    logic        spi_miso;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        spi_clk_en;
    logic        branch;
    logic [23:0] branch_target;
    logic [29:0] instr;
    logic [28:0] next_instr;
    logic [2:0]  cycle;
    logic [4:0]  counter;
    logic        pc;
`ifdef NANOV_FETCH_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    nanov_spi_fetch #(.RESET_ADDR(24'h000000)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_miso     (spi_miso),
        .spi_mosi     (spi_mosi),
        .spi_cs_n     (spi_cs_n),
        .spi_clk_en   (spi_clk_en),
        .branch       (branch),
        .branch_target(branch_target),
        .instr        (instr),
        .next_instr   (next_instr),
        .cycle        (cycle),
        .counter      (counter),
        .pc           (pc)
`ifdef NANOV_FETCH_REDIRECT_CNT_EN
        ,
        .redirect_cnt (redirect_cnt)
`endif
    );

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] W00  = 32'h0050_0093;
    localparam logic [31:0] W04  = 32'h00a0_0113;
    localparam logic [31:0] W08  = 32'h00f0_0193;
    localparam logic [31:0] W0C  = 32'h0140_0213;
    localparam logic [31:0] W10  = 32'h0220_82b3;
    localparam logic [31:0] W14  = 32'h0030_0313;
    localparam logic [31:0] W18  = 32'h0ec0_006f;
    localparam logic [31:0] W1C  = 32'h0070_0393;
    localparam logic [31:0] W104 = 32'h0630_0413;
    localparam logic [31:0] W108 = 32'h0010_0493;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash: 32 command bits in, then data bytes from the captured address.
    logic [31:0] mem [0:127];
    int          bitcnt;
    logic [31:0] fcmd;
    int          fn;
    logic [23:0] fa;
    logic [31:0] fw;
    logic [7:0]  fb;

    always @(posedge clk) begin
        if (spi_cs_n) begin
            bitcnt <= 0;
        end else if (spi_clk_en) begin
            if (bitcnt < 32) fcmd <= {fcmd[30:0], spi_mosi};
            bitcnt <= bitcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!spi_cs_n && bitcnt >= 32) begin
            fn = bitcnt - 32;
            fa = fcmd[23:0] + 24'(fn / 8);
            fw = mem[fa[8:2]];
            fb = fw[8 * fa[1:0] +: 8];
            spi_miso = fb[7 - (fn % 8)];
        end else begin
            spi_miso = 1'b0;
        end
    end

    // Observations collected over one 32-clock slot.
    logic [31:0] sm_mosi, sm_pc;
    int          sm_en, sm_cs;
    logic [29:0] sm_instr0;
    logic [2:0]  sm_cyc0;
    logic [28:0] sm_nx0, sm_nx31;
    logic [4:0]  sm_cnt0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hi30(input logic [31:0] w);
        return {2'b00, w[31:2]};
    endfunction

    function automatic logic [31:0] mid29(input logic [31:0] w);
        return {3'b000, w[30:2]};
    endfunction

    task automatic slot(input int br_at, input logic [23:0] tgt);
        sm_en = 0;
        sm_cs = 0;
        for (int i = 0; i < 32; i++) begin
            sm_mosi[31 - i] = spi_mosi;
            sm_pc[i]        = pc;
            sm_en += int'(spi_clk_en);
            sm_cs += int'(spi_cs_n);
            if (i == 0) begin
                sm_instr0 = instr;
                sm_cyc0   = cycle;
                sm_nx0    = next_instr;
                sm_cnt0   = counter;
            end
            if (i == 31) sm_nx31 = next_instr;
            if (i == br_at) begin
                branch        = 1'b1;
                branch_target = tgt;
            end
            step();
            branch = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = NOP;
        mem[0]  = W00;  mem[1] = W04; mem[2] = W08; mem[3] = W0C;
        mem[4]  = W10;  mem[5] = W14; mem[6] = W18; mem[7] = W1C;
        mem[65] = W104; mem[66] = W108;
        rst = 1'b1;
        branch = 1'b0;
        branch_target = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_clk_en", 32'(spi_clk_en), 32'd0);
        chk("rst_instr", 32'(instr), hi30(NOP));
        chk("rst_cycle", 32'(cycle), 32'd0);
        chk("rst_counter", 32'(counter), 32'd0);
`ifdef NANOV_FETCH_REDIRECT_CNT_EN
        chk("rst_redirect_cnt", 32'(redirect_cnt), 32'd0);
`endif

        slot(-1, 24'h0);
        chk("flush_cs_hi", 32'(sm_cs), 32'd32);
        chk("flush_en", 32'(sm_en), 32'd0);
        slot(-1, 24'h0);
        chk("cmd_mosi", sm_mosi, 32'h0300_0000);
        chk("cmd_en", 32'(sm_en), 32'd32);
        chk("cmd_cs_hi", 32'(sm_cs), 32'd0);
        chk("flash_cmd", fcmd, 32'h0300_0000);
        slot(-1, 24'h0);
        chk("fill_instr_nop", 32'(sm_instr0), hi30(NOP));
        chk("fill_mosi", sm_mosi, 32'h0);

        // Slots 3..6: sequential single-cycle addi.
        slot(-1, 24'h0);
        chk("i00_instr", 32'(sm_instr0), hi30(W00));
        chk("i00_counter", 32'(sm_cnt0), 32'd0);
        chk("i00_pc", sm_pc, 32'h0);
        chk("i00_en", 32'(sm_en), 32'd32);
        slot(-1, 24'h0);
        chk("i04_instr", 32'(sm_instr0), hi30(W04));
        chk("i04_pc", sm_pc, 32'h4);
        slot(-1, 24'h0);
        chk("i08_instr", 32'(sm_instr0), hi30(W08));
        chk("i08_pc", sm_pc, 32'h8);
        slot(-1, 24'h0);
        chk("i0c_instr", 32'(sm_instr0), hi30(W0C));
        chk("i0c_pc", sm_pc, 32'hC);
        chk("i0c_en", 32'(sm_en), 32'd32);
        chk("i0c_cs_hi", 32'(sm_cs), 32'd0);

        // Slots 7..9: mul takes three sub-cycles with the flash clock stopped.
        slot(-1, 24'h0);
        chk("mul_instr", 32'(sm_instr0), hi30(W10));
        chk("mul_cyc0", 32'(sm_cyc0), 32'd0);
        slot(-1, 24'h0);
        chk("mul_cyc1", 32'(sm_cyc0), 32'd1);
        chk("mul_en1", 32'(sm_en), 32'd0);
        chk("mul_hold_start", 32'(sm_nx0), mid29(W14));
        chk("mul_hold_end", 32'(sm_nx31), mid29(W14));
        slot(-1, 24'h0);
        chk("mul_cyc2", 32'(sm_cyc0), 32'd2);
        chk("mul_en2", 32'(sm_en), 32'd0);
        chk("mul_hold_c2", 32'(sm_nx31), mid29(W14));
        slot(-1, 24'h0);
        chk("after_mul_instr", 32'(sm_instr0), hi30(W14));
        chk("after_mul_cyc", 32'(sm_cyc0), 32'd0);
        chk("after_mul_pc", sm_pc, 32'h14);

        // Slots 11..12: jal, branch pulsed at cycle 0 counter 0.
        slot(0, 24'h000104);
        chk("jal_instr", 32'(sm_instr0), hi30(W18));
        slot(-1, 24'h0);
        chk("jal_cyc1", 32'(sm_cyc0), 32'd1);
        chk("jal_en1", 32'(sm_en), 32'd0);
        slot(-1, 24'h0);
        chk("redir_flush_cs", 32'(sm_cs), 32'd32);
        chk("redir_flush_instr", 32'(sm_instr0), hi30(NOP));
        chk("redir_flush_cyc", 32'(sm_cyc0), 32'd0);
`ifdef NANOV_FETCH_REDIRECT_CNT_EN
        chk("redirect_cnt_1", 32'(redirect_cnt), 32'd1);
`endif
        slot(-1, 24'h0);
        chk("redir_cmd_mosi", sm_mosi, 32'h0300_0104);
        chk("redir_cmd_instr", 32'(sm_instr0), hi30(NOP));
        // Branch during FILL must be ignored.
        slot(5, 24'h000000);
        chk("redir_fill_instr", 32'(sm_instr0), hi30(NOP));
        slot(-1, 24'h0);
        chk("t104_instr", 32'(sm_instr0), hi30(W104));
        chk("t104_pc", sm_pc, 32'h104);
        slot(-1, 24'h0);
        chk("t108_instr", 32'(sm_instr0), hi30(W108));
        chk("t108_pc", sm_pc, 32'h108);

        // Reset in the middle of the CMD slot.
        rst = 1'b1;
        step();
        rst = 1'b0;
        slot(-1, 24'h0);
        repeat (10) step();
        chk("pre_rst_cs_n", 32'(spi_cs_n), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("mid_rst_counter", 32'(counter), 32'd0);
        chk("mid_rst_clk_en", 32'(spi_clk_en), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        slot(-1, 24'h0);
        chk("re_flush_cs", 32'(sm_cs), 32'd32);
        slot(-1, 24'h0);
        chk("re_cmd_mosi", sm_mosi, 32'h0300_0000);
        slot(-1, 24'h0);
        slot(-1, 24'h0);
        chk("re_i00_instr", 32'(sm_instr0), hi30(W00));
        chk("re_i00_pc", sm_pc, 32'h0);
`ifdef NANOV_FETCH_REDIRECT_CNT_EN
        chk("re_redirect_cnt", 32'(redirect_cnt), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nanov_spi_fetch.md
# nanov_spi_fetch

Instruction-fetch sequencer that sits directly upstream of the nanoV core. It reads the instruction stream serially from an SPI flash (READ 0x03) and generates the core's `counter`/`cycle` timebase. It assembles each prefetched instruction into `next_instr`/`instr`, supplies the serial `pc` bit, and restarts the flash read when the core signals a taken branch or jump.

## Interface
Parameters:
- `RESET_ADDR`, default 24'h000000: byte address fetched after reset; bits [1:0] are ignored.

Ports:
- `clk`  in  1  system clock; one SPI bit per clock
- `rst`  in  1  reset, asynchronous, active-high
- `spi_miso`  in  1  flash data out
- `spi_mosi`  out  1  flash data in
- `spi_cs_n`  out  1  flash select
- `spi_clk_en`  out  1  top level gates the flash SCK with this
- `branch`  in  1  core redirect request
- `branch_target`  in  24  redirect byte address; bits [1:0] ignored
- `instr`  out  30  current instruction bits [31:2]
- `next_instr`  out  29  prefetch assembly bits [30:2]
- `cycle`  out  3  instruction sub-cycle
- `counter`  out  5  bit position 0..31
- `pc`  out  1  `pc_reg[counter]`; 0 for counter ≥ 24

## Operation
- State machine states: FLUSH, CMD, FILL, RUN. Each state lasts exactly one 32-clock slot (counter 0→31), except RUN.
- `counter` increments every clock, free-running, and wraps 31→0. Every state change happens on the clock where counter==31.
- FLUSH:
  - `spi_cs_n`=1, `spi_clk_en`=0.
  - Next state is CMD.
- CMD:
  - `spi_cs_n`=0, `spi_clk_en`=1.
  - `spi_mosi` = bit (31-counter) of {8'h03, pc_reg[23:0]}, i.e. MSB first.
  - Next state is FILL.
- FILL:
  - `spi_mosi`=0, `spi_clk_en`=1; incoming bits go into the assembly register.
  - Next state is RUN. `instr` loads the completed word.
- Stream mapping: the miso bit sampled at counter k lands in instruction bit 8·(k/8) + 7 − (k%8). This gives bytes in address order, MSB-first within each byte.
- `next_instr` is the assembly register. At counter==31, bits 23:2 are already complete; bit 24 is written at that edge.
- While not in RUN:
  - `instr` = NOP 0x00000013 (bits [31:2]).
  - `cycle`=0.
- RUN, sub-cycle count `ncyc`, decoded from `instr[6:2]` and `instr[25]`:
  - 11011 or 11001 (jal/jalr): 2
  - 11000 (branch): 2
  - 00000 (load): 3
  - 01100 with instr[25]=1 (mul): 3
  - shifts (00100/01100 with funct3 001 or 101): 2
  - everything else: 1
- RUN, cycle 0: `spi_clk_en`=1 and the instruction at pc+4 streams in. In cycle > 0: `spi_clk_en`=0 and the assembly register holds.
- RUN, at counter==31:
  - If cycle < ncyc−1: cycle increments.
  - Otherwise the instruction retires: cycle←0 and `instr`←assembled word.
- Retire without a pending branch: pc_reg ← pc_reg+4 (24-bit wrap).
- `branch` sampled high in RUN sets `branch_pending`. A branch in the retiring clock itself counts.
- Retire with `branch_pending`:
  - pc_reg ← {branch_target[23:2], 2'b00}; `branch_pending` clears.
  - `instr` ← NOP; state ← FLUSH.
  - The prefetched word is discarded.
- `branch` asserted outside RUN is ignored.

## Timing
- Values after reset: state FLUSH, counter 0, cycle 0, pc_reg=RESET_ADDR, `instr`=NOP, `spi_cs_n`=1, `spi_mosi`=0, `spi_clk_en`=0, `branch_pending`=0.
- First real instruction: it is in `instr` at clock 96 after reset release (3 slots). Redirect penalty is the same 3 slots of NOP.
- Sequential single-cycle code: one instruction per 32 clocks, with no stall.
- SPI at the block boundary:
  - `spi_mosi`/`spi_cs_n` for slot k are valid throughout that clock.
  - `spi_miso` is sampled at the rising edge that ends that clock.
  - Pad skew is the top level's concern.
- Reset mid-read:
  - Reset immediately forces the reset values, including `spi_cs_n`=1.
  - On release, the flash is re-addressed from RESET_ADDR.

## Configuration
- `NANOV_FETCH_REDIRECT_CNT_EN`:
  - Defined: adds output `redirect_cnt` [15:0], reset 0. It increments once per branch retire, saturates at 16'hFFFF, and is never cleared except by reset.
  - Undefined: the port and counter do not exist; all other behaviour is identical.

## Structure
- Shared package `nanov_pkg` holds:
  - the NOP encoding constant
  - the SPI READ opcode 8'h03
  - the state enum {FLUSH, CMD, FILL, RUN}
  - the opcode constants used by the `ncyc` decode
- One sub-module, `nanov_cycle_decode`: combinational, `instr[6:2]`, `instr[25]`, `instr[14:12]` → `ncyc` [1:0].

## Test plan
- Reset with RESET_ADDR=0:
  - mosi over the CMD slot = 0x03000000.
  - Flash model returns 0x00500093 → `instr` = that word at clock 96; `spi_cs_n` rises only on `rst`.
- Four sequential single-cycle addi:
  - pc advances 0,4,8,12; each new `instr` appears at counter 0.
  - `spi_clk_en` stays 1 and the flash is read continuously.
- mul (ncyc=3):
  - `cycle` goes 0,1,2.
  - `spi_clk_en`=0 for 64 clocks; `next_instr` is held stable; the next instruction then retires correctly.
- jal with `branch` at cycle 0 counter 0, `branch_target`=0x000104:
  - After retire: FLUSH, then mosi 0x03000104, then the instruction at 0x104 after 96 clocks.
  - NOP is presented in between.
- `branch` pulsed during FILL: ignored, pc continues sequentially.
- `rst` asserted mid-CMD: `spi_cs_n`=1 immediately; re-fetch from RESET_ADDR.
- With the macro defined: 3 taken branches → `redirect_cnt`=3.
